// File: rtl/vga_dispatch_pkg.sv
// Shared constants for the instruction dispatcher: opcode classes,
// engine indices and the dispatcher state encoding.
package vga_dispatch_pkg;

    localparam logic [3:0] CLS_TEXT = 4'h0;
    localparam logic [3:0] CLS_GFX  = 4'h1;
    localparam logic [3:0] CLS_PAL  = 4'h2;

    localparam int ENG_TEXT = 0;
    localparam int ENG_GFX  = 1;
    localparam int ENG_PAL  = 2;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/dispatch_timeout.sv
// Up-counter for the engine wait window. It is reloaded to zero by clear
// and raises terminal once TIMEOUT_CYCLES-1 has been reached.
module dispatch_timeout #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [TO_W-1:0] count_reg;

    assign terminal = (count_reg == TO_W'(TIMEOUT_CYCLES - 1));

    // Saturates at the terminal value so a stalled FSM never wraps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !terminal) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_dispatcher.sv
// Latches an instruction from cpu_interface, routes it to one execution
// engine by opcode class, and reports completion, errors and results.
module instruction_dispatcher
    import vga_dispatch_pkg::*;
#(
    parameter int NUM_ENG        = 3,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 12
) (
    input  logic                  phi2,
    input  logic                  reset_n,
    input  logic [7:0]            instruction,
    input  logic [87:0]           arg_flat,
    input  logic                  instruction_start,
    output logic                  instruction_busy,
    output logic                  instruction_finished,
    output logic                  instruction_error,
    output logic [7:0]            result_0,
    output logic [7:0]            result_1,
    output logic [7:0]            cmd_opcode,
    output logic [87:0]           cmd_args,
    output logic [NUM_ENG-1:0]    eng_req,
    input  logic [NUM_ENG-1:0]    eng_done,
    input  logic [NUM_ENG-1:0]    eng_err,
    input  logic [16*NUM_ENG-1:0] eng_res_flat
);

    state_t             state_reg;
    logic               busy_reg;
    logic               finished_reg;
    logic               error_reg;
    logic [7:0]         result_0_reg;
    logic [7:0]         result_1_reg;
    logic [7:0]         cmd_opcode_reg;
    logic [87:0]        cmd_args_reg;
    logic [NUM_ENG-1:0] eng_req_reg;

    logic               timeout_hit;
    logic               done_hit;
    logic               done_err;
    logic [7:0]         res0_sel;
    logic [7:0]         res1_sel;
    logic [7:0]         res0_term [NUM_ENG];
    logic [7:0]         res1_term [NUM_ENG];

    // eng_req is one-hot, so masking with it selects the active engine and
    // makes done pulses from any other engine invisible.
    assign done_hit = |(eng_done & eng_req_reg);
    assign done_err = |(eng_done & eng_err & eng_req_reg);

    generate
        for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_res_mux
            assign res0_term[gi] = eng_req_reg[gi] ? eng_res_flat[16*gi     +: 8] : 8'h00;
            assign res1_term[gi] = eng_req_reg[gi] ? eng_res_flat[16*gi + 8 +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        res0_sel = '0;
        res1_sel = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            res0_sel = res0_sel | res0_term[i];
            res1_sel = res1_sel | res1_term[i];
        end
    end

    dispatch_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clk      (phi2),
        .rst_n    (reset_n),
        .clear    (state_reg == DECODE),
        .enable   (state_reg == WAIT),
        .terminal (timeout_hit)
    );

    always_ff @(posedge phi2 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            finished_reg   <= 1'b0;
            error_reg      <= 1'b0;
            result_0_reg   <= '0;
            result_1_reg   <= '0;
            cmd_opcode_reg <= '0;
            cmd_args_reg   <= '0;
            eng_req_reg    <= '0;
        end else begin
            finished_reg <= 1'b0;
            error_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (instruction_start) begin
                        cmd_opcode_reg <= instruction;
                        cmd_args_reg   <= arg_flat;
                        busy_reg       <= 1'b1;
                        state_reg      <= DECODE;
                    end
                end
                DECODE: begin
                    case (cmd_opcode_reg[7:4])
                        CLS_TEXT: begin
                            eng_req_reg <= NUM_ENG'(1) << ENG_TEXT;
                            state_reg   <= WAIT;
                        end
                        CLS_GFX: begin
                            eng_req_reg <= NUM_ENG'(1) << ENG_GFX;
                            state_reg   <= WAIT;
                        end
                        CLS_PAL: begin
                            eng_req_reg <= NUM_ENG'(1) << ENG_PAL;
                            state_reg   <= WAIT;
                        end
                        default: begin
                            finished_reg <= 1'b1;
                            error_reg    <= 1'b1;
                            state_reg    <= DONE;
                        end
                    endcase
                end
                WAIT: begin
                    // Done takes priority over a timeout landing on the same cycle.
                    if (done_hit) begin
                        result_0_reg <= res0_sel;
                        result_1_reg <= res1_sel;
                        finished_reg <= 1'b1;
                        error_reg    <= done_err;
                        eng_req_reg  <= '0;
                        state_reg    <= DONE;
                    end else if (timeout_hit) begin
                        finished_reg <= 1'b1;
                        error_reg    <= 1'b1;
                        eng_req_reg  <= '0;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    eng_req_reg <= '0;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign instruction_busy     = busy_reg;
    assign instruction_finished = finished_reg;
    assign instruction_error    = error_reg;
    assign result_0             = result_0_reg;
    assign result_1             = result_1_reg;
    assign cmd_opcode           = cmd_opcode_reg;
    assign cmd_args             = cmd_args_reg;
    assign eng_req              = eng_req_reg;

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed bench for instruction_dispatcher: hand-computed expectations
// for each opcode class, invalid opcodes, timeout, ignored starts and reset.
module tb_instruction_dispatcher;

    localparam int NUM_ENG        = 3;
    localparam int TIMEOUT_CYCLES = 4096;
    localparam int TO_W           = 12;

    logic         phi2;
    logic         reset_n;
    logic [7:0]   instruction;
    logic [87:0]  arg_flat;
    logic         instruction_start;
    logic         instruction_busy;
    logic         instruction_finished;
    logic         instruction_error;
    logic [7:0]   result_0;
    logic [7:0]   result_1;
    logic [7:0]   cmd_opcode;
    logic [87:0]  cmd_args;
    logic [2:0]   eng_req;
    logic [2:0]   eng_done;
    logic [2:0]   eng_err;
    logic [47:0]  eng_res_flat;

    int vec_cnt = 0;
    int err_cnt = 0;

    instruction_dispatcher #(
        .NUM_ENG        (NUM_ENG),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) dut (
        .phi2                 (phi2),
        .reset_n              (reset_n),
        .instruction          (instruction),
        .arg_flat             (arg_flat),
        .instruction_start    (instruction_start),
        .instruction_busy     (instruction_busy),
        .instruction_finished (instruction_finished),
        .instruction_error    (instruction_error),
        .result_0             (result_0),
        .result_1             (result_1),
        .cmd_opcode           (cmd_opcode),
        .cmd_args             (cmd_args),
        .eng_req              (eng_req),
        .eng_done             (eng_done),
        .eng_err              (eng_err),
        .eng_res_flat         (eng_res_flat)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    task automatic check_val(input string tag, input logic [87:0] got, input logic [87:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drives a one-cycle start pulse; returns at the negedge of the DECODE cycle.
    task automatic start_instr(input logic [7:0] op, input logic [87:0] args);
        instruction       = op;
        arg_flat          = args;
        instruction_start = 1'b1;
        @(negedge phi2);
        instruction_start = 1'b0;
    endtask

    initial begin
        int cnt;
        reset_n           = 1'b0;
        instruction       = '0;
        arg_flat          = '0;
        instruction_start = 1'b0;
        eng_done          = '0;
        eng_err           = '0;
        eng_res_flat      = '0;
        repeat (2) @(negedge phi2);
        check_val("rst_busy",     instruction_busy,     1'b0);
        check_val("rst_finished", instruction_finished, 1'b0);
        check_val("rst_error",    instruction_error,    1'b0);
        check_val("rst_results",  {result_1, result_0}, 16'h0000);
        check_val("rst_cmd",      {cmd_opcode, cmd_args}, 96'h0);
        check_val("rst_req",      eng_req,              3'b000);
        reset_n = 1'b1;
        @(negedge phi2);

        // Text engine, done five cycles after request.
        start_instr(8'h00, 88'h4107);
        check_val("t1_busy_decode", instruction_busy, 1'b1);
        check_val("t1_req_decode",  eng_req,          3'b000);
        @(negedge phi2);
        check_val("t1_req",      eng_req,         3'b001);
        check_val("t1_args",     cmd_args[15:0],  16'h4107);
        check_val("t1_opcode",   cmd_opcode,      8'h00);
        eng_res_flat[15:0] = 16'h1234;
        repeat (4) @(negedge phi2);
        check_val("t1_no_early_fin", instruction_finished, 1'b0);
        eng_done = 3'b001;
        @(negedge phi2);
        eng_done = 3'b000;
        check_val("t1_finished", instruction_finished, 1'b1);
        check_val("t1_error",    instruction_error,    1'b0);
        check_val("t1_res0",     result_0,             8'h34);
        check_val("t1_res1",     result_1,             8'h12);
        check_val("t1_req_drop", eng_req,              3'b000);
        check_val("t1_busy_done", instruction_busy,    1'b1);
        @(negedge phi2);
        check_val("t1_fin_pulse", instruction_finished, 1'b0);
        check_val("t1_busy_fall", instruction_busy,     1'b0);
        $display("txn op=00 res=%02h%02h", result_1, result_0);

        // Invalid opcode class.
        start_instr(8'h5A, 88'h0);
        check_val("t2_fin_early", instruction_finished, 1'b0);
        @(negedge phi2);
        check_val("t2_finished", instruction_finished, 1'b1);
        check_val("t2_error",    instruction_error,    1'b1);
        check_val("t2_req",      eng_req,              3'b000);
        check_val("t2_results",  {result_1, result_0}, 16'h1234);
        @(negedge phi2);
        check_val("t2_busy_fall", instruction_busy,    1'b0);
        $display("txn op=5A invalid");

        // Graphics engine never answers: timeout.
        start_instr(8'h10, 88'h0);
        @(negedge phi2);
        cnt = 0;
        while (eng_req == 3'b010 && cnt < TIMEOUT_CYCLES + 100) begin
            cnt++;
            @(negedge phi2);
        end
        check_val("t3_req_cycles", cnt,                 TIMEOUT_CYCLES);
        check_val("t3_req_drop",   eng_req,             3'b000);
        check_val("t3_finished",   instruction_finished, 1'b1);
        check_val("t3_error",      instruction_error,    1'b1);
        check_val("t3_results",    {result_1, result_0}, 16'h1234);
        @(negedge phi2);
        check_val("t3_busy_fall",  instruction_busy,     1'b0);
        $display("txn op=10 timeout after %0d cycles", cnt);

        // Palette engine with engine error; a stray done from engine 0 first.
        start_instr(8'h21, 88'h0);
        @(negedge phi2);
        check_val("t4_req", eng_req, 3'b100);
        eng_res_flat = 48'hADDE_0000_5555;
        eng_done     = 3'b001;
        @(negedge phi2);
        check_val("t4_stray_fin", instruction_finished, 1'b0);
        check_val("t4_stray_req", eng_req,              3'b100);
        eng_done = 3'b100;
        eng_err  = 3'b100;
        @(negedge phi2);
        eng_done = 3'b000;
        eng_err  = 3'b000;
        check_val("t4_finished", instruction_finished, 1'b1);
        check_val("t4_error",    instruction_error,    1'b1);
        check_val("t4_res0",     result_0,             8'hDE);
        check_val("t4_res1",     result_1,             8'hAD);
        @(negedge phi2);
        $display("txn op=21 engerr res=%02h%02h", result_1, result_0);

        // Start during WAIT and during DONE is ignored; start on first IDLE is taken.
        start_instr(8'h00, 88'hAA55);
        @(negedge phi2);
        instruction       = 8'h21;
        arg_flat          = 88'h1111;
        instruction_start = 1'b1;
        @(negedge phi2);
        instruction_start = 1'b0;
        check_val("t5_opcode_held", cmd_opcode,     8'h00);
        check_val("t5_args_held",   cmd_args[15:0], 16'hAA55);
        check_val("t5_req_held",    eng_req,        3'b001);
        eng_res_flat = 48'h0000_0000_5678;
        eng_done     = 3'b001;
        @(negedge phi2);
        eng_done = 3'b000;
        check_val("t5_finished", instruction_finished, 1'b1);
        check_val("t5_error",    instruction_error,    1'b0);
        check_val("t5_res",      {result_1, result_0}, 16'h5678);
        instruction       = 8'h10;
        instruction_start = 1'b1;
        @(negedge phi2);
        instruction_start = 1'b0;
        check_val("t5_done_start_ign", instruction_busy, 1'b0);
        check_val("t5_done_opcode",    cmd_opcode,       8'h00);
        start_instr(8'h5A, 88'h0);
        check_val("t5_idle_start", instruction_busy, 1'b1);
        check_val("t5_idle_op",    cmd_opcode,       8'h5A);
        @(negedge phi2);
        check_val("t5_idle_err",   instruction_error, 1'b1);
        @(negedge phi2);
        $display("txn op=00 with ignored starts");

        // Asynchronous reset during WAIT, then a fresh instruction.
        start_instr(8'h10, 88'h0);
        @(negedge phi2);
        check_val("t6_req", eng_req, 3'b010);
        #2 reset_n = 1'b0;
        #1 check_val("t6_async_drop", eng_req, 3'b000);
        @(negedge phi2);
        reset_n = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge phi2);
            if (instruction_finished) cnt++;
        end
        check_val("t6_no_finish", cnt,              0);
        check_val("t6_idle_busy", instruction_busy, 1'b0);
        start_instr(8'h00, 88'h0);
        @(negedge phi2);
        check_val("t6_fresh_req", eng_req, 3'b001);
        eng_res_flat = 48'h0000_0000_9ABC;
        eng_done     = 3'b001;
        @(negedge phi2);
        eng_done = 3'b000;
        check_val("t6_fresh_fin", instruction_finished, 1'b1);
        check_val("t6_fresh_res", {result_1, result_0}, 16'h9ABC);
        @(negedge phi2);
        $display("txn op=00 after reset res=%02h%02h", result_1, result_0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
